// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding select, load-use stall and redirect flush generation.
// Tracks the DEPTH instructions downstream of ID in a small shift-register scoreboard.
module fwd_hazard_unit #(
  parameter int RSIZE       = 4,
  parameter int DEPTH       = 2,
  parameter int FLUSH_SLOTS = 1,
  parameter int LINK_REG    = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [3:0]                   id_opcode,
  input  logic [RSIZE-1:0]             id_rs,
  input  logic [RSIZE-1:0]             id_rt,
  input  logic [RSIZE-1:0]             id_rd,
  input  logic                         ex_redirect,
  output logic                         stall,
  output logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rt_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rd_sel
);

  localparam int               SW         = $clog2(DEPTH + 1);
  localparam logic [RSIZE-1:0] LINK_ADDR  = RSIZE'(LINK_REG);
  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_SLOTS);

  logic [DEPTH:1]    r_valid;
  logic [DEPTH:1]    r_writes;
  logic [DEPTH:1]    r_isLoad;
  logic [RSIZE-1:0]  r_dest [1:DEPTH];
  logic [2:0]        r_flushCnt;

  logic              w_idWrites;
  logic              w_idIsLoad;
  logic [RSIZE-1:0]  w_idDest;
  logic              w_useRs;
  logic              w_useRt;
  logic              w_useRd;
  logic              w_gate;
  logic              w_loadHit;
  logic              w_accept;
  logic [DEPTH:1]    w_fwdOk;
  logic [SW-1:0]     w_rsSel;
  logic [SW-1:0]     w_rtSel;
  logic [SW-1:0]     w_rdSel;

  assign w_idWrites = (id_opcode <= 4'h8) || (id_opcode == 4'hA) ||
                      (id_opcode == 4'hB) || (id_opcode == 4'hD);
  assign w_idIsLoad = (id_opcode == 4'h8);
  assign w_idDest   = (id_opcode == 4'hD) ? LINK_ADDR : id_rd;
  assign w_useRs    = (id_opcode <= 4'h9) && (id_rs != '0);
  assign w_useRt    = (id_opcode <= 4'h3) && (id_rt != '0);
  assign w_useRd    = ((id_opcode == 4'h9) || (id_opcode == 4'hA) ||
                       (id_opcode == 4'hE) || (id_opcode == 4'hF)) && (id_rd != '0);

  assign flush = (r_flushCnt != 3'd0) || ex_redirect;

  // A load still in EX has no result yet, so it must stall rather than forward.
  assign w_loadHit = r_valid[1] && r_isLoad[1] && (r_dest[1] != '0) &&
                     ((w_useRs && (r_dest[1] == id_rs)) ||
                      (w_useRt && (r_dest[1] == id_rt)) ||
                      (w_useRd && (r_dest[1] == id_rd)));

  assign stall    = id_valid && w_loadHit && !flush;
  assign w_gate   = id_valid && !flush;
  assign w_accept = id_valid && !stall && !flush;

  always_comb begin
    w_fwdOk = '0;
    w_rsSel = '0;
    w_rtSel = '0;
    w_rdSel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_fwdOk[k] = r_valid[k] && r_writes[k] && !(r_isLoad[k] && (k == 1));
      if (w_fwdOk[k] && (r_dest[k] == id_rs)) w_rsSel = SW'(k);
      if (w_fwdOk[k] && (r_dest[k] == id_rt)) w_rtSel = SW'(k);
      if (w_fwdOk[k] && (r_dest[k] == id_rd)) w_rdSel = SW'(k);
    end
  end

  assign fwd_rs_sel = (w_gate && w_useRs) ? w_rsSel : '0;
  assign fwd_rt_sel = (w_gate && w_useRt) ? w_rtSel : '0;
  assign fwd_rd_sel = (w_gate && w_useRd) ? w_rdSel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_writes <= '0;
      r_isLoad <= '0;
      for (int k = 1; k <= DEPTH; k++) r_dest[k] <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_valid[k]  <= r_valid[k-1];
        r_writes[k] <= r_writes[k-1];
        r_isLoad[k] <= r_isLoad[k-1];
        r_dest[k]   <= r_dest[k-1];
      end
      r_valid[1]  <= w_accept;
      r_writes[1] <= w_idWrites;
      r_isLoad[1] <= w_idIsLoad;
      r_dest[1]   <= w_idDest;
    end
  end

  // A new redirect restarts the kill window rather than extending it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flushCnt <= 3'd0;
    end else if (ex_redirect) begin
      r_flushCnt <= FLUSH_LOAD;
    end else if (r_flushCnt != 3'd0) begin
      r_flushCnt <= r_flushCnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (DEPTH=2, FLUSH_SLOTS=3); expected outputs
// are queued with each stimulus step and popped when the outputs are sampled.
module tb_fwd_hazard_unit;

  localparam int RSIZE       = 4;
  localparam int DEPTH       = 2;
  localparam int FLUSH_SLOTS = 3;
  localparam int LINK_REG    = 15;
  localparam int SW          = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;

  typedef struct {
    string         tag;
    logic          check;
    logic          stall;
    logic          flush;
    logic [SW-1:0] rs;
    logic [SW-1:0] rt;
    logic [SW-1:0] rd;
  } expTxn_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_opcode;
  logic [RSIZE-1:0] id_rs;
  logic [RSIZE-1:0] id_rt;
  logic [RSIZE-1:0] id_rd;
  logic             ex_redirect;
  logic             stall;
  logic             flush;
  logic [SW-1:0]    fwd_rs_sel;
  logic [SW-1:0]    fwd_rt_sel;
  logic [SW-1:0]    fwd_rd_sel;

  expTxn_t expQ[$];
  int      testsRun  = 0;
  int      failCount = 0;

  fwd_hazard_unit #(
    .RSIZE(RSIZE), .DEPTH(DEPTH), .FLUSH_SLOTS(FLUSH_SLOTS), .LINK_REG(LINK_REG)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .stall(stall), .flush(flush),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_rd_sel(fwd_rd_sel)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input string field,
                            input logic [3:0] obs, input logic [3:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] op,
                               input logic [RSIZE-1:0] rs, input logic [RSIZE-1:0] rt,
                               input logic [RSIZE-1:0] rd, input logic redir,
                               input logic chk, input logic eStall, input logic eFlush,
                               input logic [SW-1:0] eRs, input logic [SW-1:0] eRt,
                               input logic [SW-1:0] eRd, input string tag);
    expTxn_t e;
    rst         = r;
    id_valid    = v;
    id_opcode   = op;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    ex_redirect = redir;
    e.tag   = tag;
    e.check = chk;
    e.stall = eStall;
    e.flush = eFlush;
    e.rs    = eRs;
    e.rt    = eRt;
    e.rd    = eRd;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    expTxn_t e;
    @(negedge clk);
    e = expQ.pop_front();
    if (e.check) begin
      checkField(e.tag, "stall", {3'b0, stall}, {3'b0, e.stall});
      checkField(e.tag, "flush", {3'b0, flush}, {3'b0, e.flush});
      checkField(e.tag, "rs",    4'(fwd_rs_sel), 4'(e.rs));
      checkField(e.tag, "rt",    4'(fwd_rt_sel), 4'(e.rt));
      checkField(e.tag, "rd",    4'(fwd_rd_sel), 4'(e.rd));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [RSIZE-1:0] rs, input logic [RSIZE-1:0] rt,
                      input logic [RSIZE-1:0] rd, input logic redir,
                      input logic eStall, input logic eFlush,
                      input logic [SW-1:0] eRs, input logic [SW-1:0] eRt,
                      input logic [SW-1:0] eRd, input string tag);
    applyStimulus(r, v, op, rs, rt, rd, redir, !r, eStall, eFlush, eRs, eRt, eRd, tag);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_opcode = 4'h0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //    r  v  op      rs  rt  rd  rdr  stl fl  rs rt rd  tag
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "reset");
    step(0, 1, OP_ADD,  1,  2,  3,  0,   0,  0,  0, 0, 0, "add_r3");
    step(0, 1, OP_SUB,  3,  5,  4,  0,   0,  0,  1, 0, 0, "sub_fwd_ex");
    step(0, 1, OP_LW,   1,  0,  6,  0,   0,  0,  0, 0, 0, "lw_r6");
    step(0, 1, OP_ADD,  6,  6,  7,  0,   1,  0,  0, 0, 0, "load_use_stall");
    step(0, 1, OP_ADD,  6,  6,  7,  0,   0,  0,  2, 2, 0, "load_use_fwd_mem");

    step(0, 1, OP_JAL,  0,  0,  0,  0,   0,  0,  0, 0, 0, "jal1");
    step(0, 1, OP_JR,   0,  0, 15,  0,   0,  0,  0, 0, 1, "jr_fwd_ex");
    step(0, 1, OP_JAL,  0,  0,  0,  0,   0,  0,  0, 0, 0, "jal2");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "nop_a");
    step(0, 1, OP_JR,   0,  0, 15,  0,   0,  0,  0, 0, 2, "jr_fwd_mem");
    step(0, 1, OP_JAL,  0,  0,  0,  0,   0,  0,  0, 0, 0, "jal3");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "nop_b");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "nop_c");
    step(0, 1, OP_JR,   0,  0, 15,  0,   0,  0,  0, 0, 0, "jr_no_fwd");

    step(0, 1, OP_ADD,  1,  2,  0,  0,   0,  0,  0, 0, 0, "add_r0");
    step(0, 1, OP_OR,   0,  0,  5,  0,   0,  0,  0, 0, 0, "or_r0_src");
    step(0, 1, OP_ADD,  1,  1,  2,  0,   0,  0,  0, 0, 0, "add_r2_a");
    step(0, 1, OP_ADD,  1,  1,  2,  0,   0,  0,  0, 0, 0, "add_r2_b");
    step(0, 1, OP_SUB,  2,  2,  9,  0,   0,  0,  1, 1, 0, "youngest_wins");
    step(0, 1, OP_SW,   2,  0,  2,  0,   0,  0,  2, 0, 2, "sw_store_data");

    step(0, 1, OP_ADD,  9,  0,  1,  1,   0,  1,  0, 0, 0, "flush_gate");
    step(0, 1, OP_ADD,  9,  0,  1,  0,   0,  1,  0, 0, 0, "flush_slot1");
    step(0, 1, OP_ADD,  9,  0,  1,  0,   0,  1,  0, 0, 0, "flush_slot2");
    step(0, 1, OP_ADD,  9,  0,  1,  0,   0,  1,  0, 0, 0, "flush_slot3");
    step(0, 1, OP_ADD,  9,  0,  1,  0,   0,  0,  0, 0, 0, "flush_done");

    step(0, 0, OP_ADD,  0,  0,  0,  1,   0,  1,  0, 0, 0, "redir_a");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "redir_a_s1");
    step(0, 0, OP_ADD,  0,  0,  0,  1,   0,  1,  0, 0, 0, "redir_b");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "redir_b_s1");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "redir_b_s2");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "redir_b_s3");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "redir_b_done");

    step(0, 1, OP_LW,   0,  0,  6,  0,   0,  0,  0, 0, 0, "lw_r6_b");
    step(0, 1, OP_ADD,  6,  6,  7,  1,   0,  1,  0, 0, 0, "stall_vs_flush");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "flu_s1");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "flu_s2");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  1,  0, 0, 0, "flu_s3");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "flu_done");

    step(0, 1, OP_LW,   0,  0,  6,  0,   0,  0,  0, 0, 0, "lw_r6_c");
    step(1, 1, OP_ADD,  6,  6,  7,  0,   0,  0,  0, 0, 0, "rst_mid_stall");
    step(0, 1, OP_ADD,  6,  6,  7,  0,   0,  0,  0, 0, 0, "rst_clears_stall");

    step(0, 1, OP_LW,   0,  0,  6,  0,   0,  0,  0, 0, 0, "lw_r6_d");
    step(1, 1, OP_ADD,  6,  6,  7,  1,   0,  0,  0, 0, 0, "rst_lu_flush");
    step(0, 1, OP_ADD,  6,  6,  7,  0,   0,  0,  0, 0, 0, "rst_clears_lu_flush");

    step(0, 0, OP_ADD,  0,  0,  0,  1,   0,  1,  0, 0, 0, "flush_pre_rst");
    step(1, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "rst_mid_flush");
    step(0, 0, OP_ADD,  0,  0,  0,  0,   0,  0,  0, 0, 0, "rst_clears_flush");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
